seg7_scan: RTL

- Consumer end of the 1 kHz scan-clock interface. It samples the divided scan clock `clk_1K` in the system clock domain and rotates through DIGITS multiplexed common-anode 7-segment digits.
- Hex-decodes a snapshot of a display word from the CPU datapath (PC, register or result display on the board).
- Watchdog: if scan ticks stop arriving, the display is blanked and a status flag is raised.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan_if.sv | 26 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan.sv | 110 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low: a 0 bit lights that segment.
package seg7_pkg;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex digit to active-low segment pattern ({g..a}).
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus between the CPU datapath (master) and the scanner (slave).
//   en        display enable
//   data      display word, digit i = data[4i+3:4i]
//   blank     per-digit blank
//   dp        per-digit decimal point, active-high
//   an        digit anodes, active-low
//   seg       segments {g..a}, active-low
//   dp_n      decimal point, active-low
//   tick_lost scan-tick watchdog flag
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic                  tick_lost;

  modport master (output en, data, blank, dp,
                  input  an, seg, dp_n, tick_lost);
  modport slave  (input  en, data, blank, dp,
                  output an, seg, dp_n, tick_lost);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-7-segment decoder.
//   nib_i  4-bit hex value
//   seg_o  active-low segments {g..a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = hex7(nib_i);
  end
endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment scanner driven by a 1 kHz scan clock
// from the same clock domain, with a per-frame snapshot of the display word
// and a watchdog that blanks the display when scan ticks stop.
//   clk     system clock
//   reset   synchronous, active-high reset
//   clk_1K  divided scan clock (same domain, no synchronizer)
//   bus     display interface (slave side): en/data/blank/dp in,
//           an/seg/dp_n/tick_lost out (all outputs registered)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned TIMEOUT = 200000,
  parameter int unsigned WD_W    = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1K,
  seg7_scan_if.slave  bus
);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);

  logic                clk_1K_q;
  logic                tick;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [4*DIGITS-1:0] data_s_q;
  logic [DIGITS-1:0]   blank_s_q, dp_s_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic                tick_lost_q, tick_lost_d;
  logic                snap;
  logic [3:0]          nib;
  logic [6:0]          nib_seg;

  assign tick = clk_1K & ~clk_1K_q;
  assign snap = tick & (idx_q == IDX_LAST);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (tick) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
    tick_lost_d = (wd_q == WD_MAX) & ~tick;
  end

  assign nib = data_s_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  // Output stage uses the registered tick_lost, so anodes resume one
  // cycle after the flag clears.
  always_comb begin
    an_d   = '1;
    if (bus.en && !tick_lost_q) begin
      an_d = ~(DIGITS'(1) << idx_q);
    end
    seg_d  = blank_s_q[idx_q] ? SEG_OFF : nib_seg;
    dp_n_d = ~dp_s_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_1K_q    <= 1'b1;   // no tick if clk_1K is already high out of reset
      idx_q       <= '0;
      wd_q        <= '0;
      data_s_q    <= '0;
      blank_s_q   <= '0;
      dp_s_q      <= '0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_n_q      <= 1'b1;
      tick_lost_q <= 1'b0;
    end else begin
      clk_1K_q    <= clk_1K;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      if (snap) begin
        data_s_q  <= bus.data;
        blank_s_q <= bus.blank;
        dp_s_q    <= bus.dp;
      end
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      tick_lost_q <= tick_lost_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp_n      = dp_n_q;
  assign bus.tick_lost = tick_lost_q;

endmodule
